hps_pitch_detector: RTL and testbench
=====================================

HPS_PITCH_DETECTOR -- requirements
Module: hps_pitch_detector

Interface
REQ-001 Parameter K_WIDTH, default 12, SHALL be log2 of FFT length N; the RAM holds N/2 bins, indices 0..N/2-1.
REQ-002 Parameter MAG_WIDTH, default 32, SHALL be the width of magnitudes, RAM words and the HPS product.
REQ-003 Parameter MAX_HARMONICS, default 5, SHALL be the largest harmonic count supported (range 1..7).
REQ-004 Parameter FRAC_SHIFT, default 16, SHALL be the right shift applied after each harmonic multiply.
REQ-005 Parameter MIN_BIN, default 1, SHALL be the first fundamental bin scanned.
REQ-006 Port clock, input, 1: the only clock; all logic SHALL be rising-edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port mag_valid, input, 1: a magnitude beat is present.
REQ-009 Port mag_data, input, MAG_WIDTH: unsigned magnitude.
REQ-010 Port mag_k, input, K_WIDTH: bin index of the beat.
REQ-011 Port mag_last, input, 1: final beat of the frame, qualified by mag_valid.
REQ-012 Port num_harmonics, input, 3: harmonic count H for the next scan.
REQ-013 Port busy, output, 1: high while scanning.
REQ-014 Port overrun, output, 1: one-cycle pulse when a beat is dropped.
REQ-015 Port k_max, output, K_WIDTH-1: winning fundamental bin.
REQ-016 Port peak, output, MAG_WIDTH: HPS value at k_max.
REQ-017 Port k_max_valid, output, 1: one-cycle result pulse.

Function
REQ-018 The FSM SHALL have states CAPTURE, SCAN and REPORT, and SHALL leave reset in CAPTURE.
REQ-019 In CAPTURE, a beat with mag_valid=1 and mag_k < N/2 SHALL write mag_data to RAM[mag_k]; beats with mag_k >= N/2 SHALL be ignored, not flagged.
REQ-020 A beat with mag_valid and mag_last in CAPTURE SHALL be written if in range, and the FSM SHALL enter SCAN on the next cycle.
REQ-021 On SCAN entry, H SHALL be latched from num_harmonics: 0 is treated as 1, and values above MAX_HARMONICS clamp to MAX_HARMONICS.
REQ-022 SCAN SHALL visit k from MIN_BIN to K_END = floor((N/2-1)/H) inclusive. If K_END < MIN_BIN, no k is visited and the FSM goes directly to REPORT with k_max=0 and peak=0.
REQ-023 For each k, one RAM read SHALL be issued per cycle at addresses k, 2k, ..., Hk (H cycles per k); the multiplier index SHALL be generated by repeated addition, not by multiplication.
REQ-024 The product SHALL be computed as follows.
- p1 = mag[k].
- p(j) = sat((p(j-1) * mag[jk]) >> FRAC_SHIFT), where sat saturates to 2^MAG_WIDTH-1.
- The full 2*MAG_WIDTH intermediate product SHALL be kept before the shift.
REQ-025 Peak tracking SHALL replace the running maximum only on strictly greater values, so ties keep the lowest k; the running maximum SHALL be cleared on SCAN entry.
REQ-026 After the last product is final, the FSM SHALL enter REPORT and hold there for one cycle.
- In REPORT, k_max and peak SHALL update and k_max_valid SHALL pulse.
- The FSM SHALL then return to CAPTURE.
REQ-027 Latency from the mag_last cycle to k_max_valid SHALL be at most (K_END-MIN_BIN+1)*H + 4 cycles.
REQ-028 busy SHALL be high in SCAN and REPORT.
REQ-029 A mag_valid beat arriving while busy SHALL NOT write RAM and SHALL pulse overrun; mag_last in that beat SHALL be ignored.
REQ-030 k_max and peak SHALL hold their last value until the next REPORT.
REQ-031 RAM contents SHALL persist across frames; bins not rewritten keep stale data.

Reset
REQ-032 Reset SHALL force the following.
- FSM to CAPTURE.
- busy, overrun and k_max_valid to 0.
- k_max and peak to 0.
- Scan counters and running maximum to 0.
REQ-033 Reset asserted during SCAN SHALL abort the scan with no k_max_valid pulse.
REQ-034 RAM contents SHALL NOT be reset.

Structure
REQ-035 Package hps_pkg SHALL hold:
- the FSM state enum;
- N/2 and K_END helper functions;
- the saturating-multiply width constant.
REQ-036 One sub-module, hps_bin_sequencer, SHALL generate the (k, j, address, first, last) read sequence; the RAM, multiplier and peak tracker SHALL stay in the top level.

Verification
REQ-037 Single harmonic:
- Stimulus: K_WIDTH=5, H=3, all bins 0 except mag[2]=mag[4]=mag[6]=0x10000.
- Response: k_max=2, peak=0x10000, exactly one k_max_valid pulse.
REQ-038 Tie:
- Stimulus: H=1, mag[3]=mag[7]=500, other bins below 500.
- Response: k_max=3, peak=500.
REQ-039 Saturation:
- Stimulus: H=2, FRAC_SHIFT=0, mag[4]=mag[8]=0xFFFFFFFF.
- Response: peak=0xFFFFFFFF.
REQ-040 Overrun:
- Stimulus: drive 3 beats during SCAN.
- Response: 3 overrun pulses, RAM unchanged, result equal to an undisturbed run.
REQ-041 Range check:
- Stimulus: num_harmonics=7 with MAX_HARMONICS=5.
- Response: scan uses H=5, K_END=floor(15/5)=3 for K_WIDTH=5.
REQ-042 Reset mid-SCAN:
- Stimulus: assert reset mid-SCAN.
- Response: busy=0 next edge, no k_max_valid, and the next frame yields a correct result.

Source files
------------

// File: rtl/hps_pkg.sv
// Shared types, helpers and width constants for the harmonic product spectrum pitch detector.
package hps_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_SCAN    = 2'd1,
        ST_REPORT  = 2'd2
    } hps_state_e;

    // The harmonic product is formed at this multiple of the magnitude width before shifting.
    localparam int unsigned SAT_MUL_FACTOR = 2;

    // Number of stored bins (half the FFT length).
    function automatic int unsigned half_n(input int unsigned k_width);
        return 32'd1 << (k_width - 32'd1);
    endfunction

    // Last fundamental bin whose H-th harmonic still lies inside the stored half spectrum.
    // Division is by a constant in every branch so no divider is built.
    function automatic int unsigned k_end(input int unsigned k_width, input logic [2:0] h);
        int unsigned top_bin;
        int unsigned result;
        top_bin = half_n(k_width) - 32'd1;
        case (h)
            3'd2:    result = top_bin / 32'd2;
            3'd3:    result = top_bin / 32'd3;
            3'd4:    result = top_bin / 32'd4;
            3'd5:    result = top_bin / 32'd5;
            3'd6:    result = top_bin / 32'd6;
            3'd7:    result = top_bin / 32'd7;
            default: result = top_bin;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hps_bin_sequencer.sv
// Walks k = MIN_BIN..K_END and, for each k, the harmonic addresses k, 2k, ..., Hk, one per cycle.
module hps_bin_sequencer
    import hps_pkg::*;
#(
    parameter int unsigned K_WIDTH = 12,
    parameter int unsigned MIN_BIN = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_start,
    input  logic [2:0]         i_h,
    output logic               o_valid,
    output logic [K_WIDTH-2:0] o_k,
    output logic [K_WIDTH-2:0] o_addr,
    output logic               o_first,
    output logic               o_last
);

    localparam int unsigned BIN_W = K_WIDTH - 1;

    logic [BIN_W-1:0] r_k;
    logic [BIN_W-1:0] r_addr;
    logic [BIN_W-1:0] r_kend;
    logic [2:0]       r_h;
    logic [2:0]       r_j;
    logic             r_valid;
    logic             r_first;
    logic             r_last;

    // Address advances by repeated addition of k; a new k starts when the H-th harmonic was issued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_k     <= '0;
            r_addr  <= '0;
            r_kend  <= '0;
            r_h     <= '0;
            r_j     <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_start) begin
            r_h     <= i_h;
            r_kend  <= BIN_W'(k_end(K_WIDTH, i_h));
            r_k     <= BIN_W'(MIN_BIN);
            r_addr  <= BIN_W'(MIN_BIN);
            r_j     <= 3'd1;
            r_first <= 1'b1;
            r_last  <= (i_h == 3'd1);
            r_valid <= (k_end(K_WIDTH, i_h) >= MIN_BIN);
        end else if (r_valid) begin
            if (r_last) begin
                r_j     <= 3'd1;
                r_first <= 1'b1;
                r_last  <= (r_h == 3'd1);
                if (r_k == r_kend) begin
                    r_valid <= 1'b0;
                end else begin
                    r_k    <= r_k + BIN_W'(1);
                    r_addr <= r_k + BIN_W'(1);
                end
            end else begin
                r_j     <= r_j + 3'd1;
                r_addr  <= r_addr + r_k;
                r_first <= 1'b0;
                r_last  <= ((r_j + 3'd1) == r_h);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_k     = r_k;
    assign o_addr  = r_addr;
    assign o_first = r_first;
    assign o_last  = r_last;

endmodule

// File: rtl/hps_pitch_detector.sv
// Captures a half magnitude spectrum, scans the harmonic product spectrum and reports its peak bin.
module hps_pitch_detector
    import hps_pkg::*;
#(
    parameter int unsigned K_WIDTH       = 12,
    parameter int unsigned MAG_WIDTH     = 32,
    parameter int unsigned MAX_HARMONICS = 5,
    parameter int unsigned FRAC_SHIFT    = 16,
    parameter int unsigned MIN_BIN       = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mag_valid,
    input  logic [MAG_WIDTH-1:0] mag_data,
    input  logic [K_WIDTH-1:0]   mag_k,
    input  logic                 mag_last,
    input  logic [2:0]           num_harmonics,
    output logic                 busy,
    output logic                 overrun,
    output logic [K_WIDTH-2:0]   k_max,
    output logic [MAG_WIDTH-1:0] peak,
    output logic                 k_max_valid
);

    localparam int unsigned BIN_W    = K_WIDTH - 1;
    localparam int unsigned NUM_BINS = half_n(K_WIDTH);
    localparam int unsigned PROD_W   = SAT_MUL_FACTOR * MAG_WIDTH;
    localparam logic [MAG_WIDTH-1:0] MAG_MAX = '1;

    hps_state_e r_state;
    hps_state_e w_state_next;

    logic [MAG_WIDTH-1:0] r_ram [NUM_BINS];
    logic [MAG_WIDTH-1:0] r_rd_data;

    logic                 w_capture;
    logic                 w_start;
    logic [2:0]           w_h;

    logic                 w_seq_valid;
    logic [BIN_W-1:0]     w_seq_k;
    logic [BIN_W-1:0]     w_seq_addr;
    logic                 w_seq_first;
    logic                 w_seq_last;

    logic                 r_s1_valid;
    logic                 r_s1_first;
    logic                 r_s1_last;
    logic [BIN_W-1:0]     r_s1_k;

    logic [PROD_W-1:0]    w_full;
    logic [PROD_W-1:0]    w_shifted;
    logic [MAG_WIDTH-1:0] w_prod_next;
    logic [MAG_WIDTH-1:0] r_prod;
    logic [MAG_WIDTH-1:0] r_best_val;
    logic [BIN_W-1:0]     r_best_k;

    logic                 r_busy;
    logic                 r_overrun;
    logic                 r_kv;
    logic [BIN_W-1:0]     r_k_max;
    logic [MAG_WIDTH-1:0] r_peak;

    assign w_capture = (r_state == ST_CAPTURE);
    assign w_start   = w_capture && mag_valid && mag_last;

    // Harmonic count seen at scan start: 0 means a plain spectrum peak, large values clamp.
    always_comb begin
        w_h = num_harmonics;
        if (num_harmonics == 3'd0) begin
            w_h = 3'd1;
        end else if (num_harmonics > 3'(MAX_HARMONICS)) begin
            w_h = 3'(MAX_HARMONICS);
        end
    end

    hps_bin_sequencer #(
        .K_WIDTH (K_WIDTH),
        .MIN_BIN (MIN_BIN)
    ) u_seq (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_start),
        .i_h     (w_h),
        .o_valid (w_seq_valid),
        .o_k     (w_seq_k),
        .o_addr  (w_seq_addr),
        .o_first (w_seq_first),
        .o_last  (w_seq_last)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Scan ends once the sequencer and the multiply stage have both drained.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CAPTURE: if (w_start) w_state_next = ST_SCAN;
            ST_SCAN:    if (!w_seq_valid && !r_s1_valid) w_state_next = ST_REPORT;
            ST_REPORT:  w_state_next = ST_CAPTURE;
            default:    w_state_next = ST_CAPTURE;
        endcase
    end

    // Spectrum RAM: written only while capturing in-range bins, read synchronously; never reset.
    always_ff @(posedge clock) begin
        if (w_capture && mag_valid && !mag_k[K_WIDTH-1]) begin
            r_ram[mag_k[BIN_W-1:0]] <= mag_data;
        end
        r_rd_data <= r_ram[w_seq_addr];
    end

    // Fractional multiply of the running product with the current harmonic, saturating on overflow.
    always_comb begin
        w_full    = PROD_W'(r_prod) * PROD_W'(r_rd_data);
        w_shifted = w_full >> FRAC_SHIFT;
        if (r_s1_first) begin
            w_prod_next = r_rd_data;
        end else if (w_shifted[PROD_W-1:MAG_WIDTH] != '0) begin
            w_prod_next = MAG_MAX;
        end else begin
            w_prod_next = w_shifted[MAG_WIDTH-1:0];
        end
    end

    // Product accumulation and strictly-greater peak tracking, aligned with the RAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_k     <= '0;
            r_prod     <= '0;
            r_best_val <= '0;
            r_best_k   <= '0;
        end else begin
            r_s1_valid <= w_seq_valid;
            r_s1_first <= w_seq_first;
            r_s1_last  <= w_seq_last;
            r_s1_k     <= w_seq_k;
            if (w_start) begin
                r_best_val <= '0;
                r_best_k   <= '0;
            end else if (r_s1_valid) begin
                r_prod <= w_prod_next;
                if (r_s1_last && (w_prod_next > r_best_val)) begin
                    r_best_val <= w_prod_next;
                    r_best_k   <= r_s1_k;
                end
            end
        end
    end

    // Registered status and result outputs; the result is loaded on entry to REPORT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_kv      <= 1'b0;
            r_k_max   <= '0;
            r_peak    <= '0;
        end else begin
            r_busy    <= (w_state_next != ST_CAPTURE);
            r_overrun <= mag_valid && !w_capture;
            r_kv      <= (w_state_next == ST_REPORT);
            if (w_state_next == ST_REPORT) begin
                r_k_max <= r_best_k;
                r_peak  <= r_best_val;
            end
        end
    end

    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign k_max_valid = r_kv;
    assign k_max       = r_k_max;
    assign peak        = r_peak;

endmodule

// File: tb/tb_hps_pitch_detector.sv
// Bench for hps_pitch_detector: two instances (fractional shift 16 and 0) share one stimulus stream.
module tb_hps_pitch_detector;

    localparam int NB  = 16;
    localparam int TOP = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        mag_valid;
    logic [31:0] mag_data;
    logic [4:0]  mag_k;
    logic        mag_last;
    logic [2:0]  num_harmonics;

    logic        busy16, ovr16, kv16, busy0, ovr0, kv0;
    logic [3:0]  kmax16, kmax0;
    logic [31:0] peak16, peak0;

    always #5 clock = ~clock;

    hps_pitch_detector #(.K_WIDTH(5), .MAG_WIDTH(32), .MAX_HARMONICS(5), .FRAC_SHIFT(16), .MIN_BIN(1)) u_dut16 (
        .clock(clock), .reset(reset), .mag_valid(mag_valid), .mag_data(mag_data), .mag_k(mag_k),
        .mag_last(mag_last), .num_harmonics(num_harmonics), .busy(busy16), .overrun(ovr16),
        .k_max(kmax16), .peak(peak16), .k_max_valid(kv16));

    hps_pitch_detector #(.K_WIDTH(5), .MAG_WIDTH(32), .MAX_HARMONICS(5), .FRAC_SHIFT(0), .MIN_BIN(1)) u_dut0 (
        .clock(clock), .reset(reset), .mag_valid(mag_valid), .mag_data(mag_data), .mag_k(mag_k),
        .mag_last(mag_last), .num_harmonics(num_harmonics), .busy(busy0), .overrun(ovr0),
        .k_max(kmax0), .peak(peak0), .k_max_valid(kv0));

    typedef struct packed {
        logic [3:0]  k16;
        logic [31:0] p16;
        logic [3:0]  k0;
        logic [31:0] p0;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mram  [NB];
    logic [31:0] fbins [NB];
    int          total = 0;
    int          bad   = 0;
    int          n_rep = 0;
    int          n_ovr16 = 0;
    int          n_ovr0  = 0;
    logic [3:0]  held_k16 = '0, held_k0 = '0;
    logic [31:0] held_p16 = '0, held_p0 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: harmonic product spectrum straight from the definition.
    function automatic logic [35:0] model(input int h_req, input int shift);
        int              h;
        int              bk;
        longint unsigned p;
        longint unsigned best;
        h    = (h_req == 0) ? 1 : ((h_req > 5) ? 5 : h_req);
        best = 0;
        bk   = 0;
        for (int k = 1; k * h <= TOP; k++) begin
            p = {32'd0, mram[k]};
            for (int j = 2; j <= h; j++) begin
                p = (p * {32'd0, mram[j * k]}) >> shift;
                if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
            end
            if (p > best) begin
                best = p;
                bk   = k;
            end
        end
        return {4'(bk), 32'(best)};
    endfunction

    task automatic push_exp(input int h);
        logic [35:0] a, b;
        exp_t        e;
        a = model(h, 16);
        b = model(h, 0);
        e.k16 = a[35:32];
        e.p16 = a[31:0];
        e.k0  = b[35:32];
        e.p0  = b[31:0];
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [4:0] k, input logic [31:0] d, input logic last, input logic track);
        mag_valid = 1'b1;
        mag_k     = k;
        mag_data  = d;
        mag_last  = last;
        if (track && (k < 5'd16)) mram[k[3:0]] = d;
        @(posedge clock);
        #1;
        mag_valid = 1'b0;
        mag_last  = 1'b0;
    endtask

    task automatic send_frame(input int h);
        num_harmonics = 3'(h);
        for (int i = 0; i < TOP; i++) beat(5'(i), fbins[i], 1'b0, 1'b1);
        mram[TOP] = fbins[TOP];
        push_exp(h);
        beat(5'(TOP), fbins[TOP], 1'b1, 1'b1);
    endtask

    task automatic send_last_only(input int h);
        num_harmonics = 3'(h);
        mram[0] = 32'd0;
        push_exp(h);
        beat(5'd0, 32'd0, 1'b1, 1'b1);
    endtask

    task automatic wait_result(input int bound, input string name);
        int start;
        int cyc;
        start = n_rep;
        cyc   = 0;
        while ((n_rep == start) && (cyc < bound)) begin
            @(posedge clock);
            #2;
            cyc++;
        end
        total++;
        if (n_rep == start) begin
            bad++;
            $display("FAIL %s_latency: no k_max_valid within %0d cycles", name, bound);
        end
        repeat (3) @(posedge clock);
        #1;
        check({name, "_pulses"}, 64'(n_rep - start), 64'd1);
    endtask

    task automatic check_result(input string name, input logic [3:0] k16, input logic [31:0] p16,
                                input logic [3:0] k0, input logic [31:0] p0);
        check({name, "_k16"}, 64'(kmax16), 64'(k16));
        check({name, "_p16"}, 64'(peak16), 64'(p16));
        check({name, "_k0"},  64'(kmax0),  64'(k0));
        check({name, "_p0"},  64'(peak0),  64'(p0));
    endtask

    // Compare process: results must match the model at every pulse and hold in between.
    always @(negedge clock) begin
        if (reset) begin
            held_k16 = '0;
            held_p16 = '0;
            held_k0  = '0;
            held_p0  = '0;
        end else begin
            if (ovr16) n_ovr16++;
            if (ovr0)  n_ovr0++;
            if (kv16 || kv0) begin
                n_rep++;
                check("kv16_pulse", 64'(kv16), 64'd1);
                check("kv0_pulse",  64'(kv0),  64'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_report: k_max_valid with no frame pending at %0t", $time);
                end else begin
                    mon_e    = exp_q.pop_front();
                    held_k16 = mon_e.k16;
                    held_p16 = mon_e.p16;
                    held_k0  = mon_e.k0;
                    held_p0  = mon_e.p0;
                end
            end
            check("mon_k16", 64'(kmax16), 64'(held_k16));
            check("mon_p16", 64'(peak16), 64'(held_p16));
            check("mon_k0",  64'(kmax0),  64'(held_k0));
            check("mon_p0",  64'(peak0),  64'(held_p0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o16, o0, r0;
        reset         = 1'b1;
        mag_valid     = 1'b0;
        mag_data      = '0;
        mag_k         = '0;
        mag_last      = 1'b0;
        num_harmonics = 3'd1;
        for (int i = 0; i < NB; i++) mram[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_busy0",  64'(busy0),  64'd0);
        check("rst_ovr16",  64'(ovr16),  64'd0);
        check("rst_kv16",   64'(kv16),   64'd0);
        check_result("rst", 4'd0, 32'd0, 4'd0, 32'd0);

        // Single harmonic peak at bin 2 with H=3.
        for (int i = 0; i < NB; i++) fbins[i] = '0;
        fbins[2] = 32'h1_0000; fbins[4] = 32'h1_0000; fbins[6] = 32'h1_0000;
        send_frame(3);
        check("busy_in_scan", 64'(busy16), 64'd1);
        wait_result(5 * 3 + 4, "single");
        check_result("single", 4'd2, 32'h1_0000, 4'd2, 32'hFFFF_FFFF);

        // Tie between bins 3 and 7 keeps the lower bin; an out-of-range beat is dropped silently.
        for (int i = 0; i < NB; i++) fbins[i] = 32'(i * 10);
        fbins[3] = 32'd500; fbins[7] = 32'd500;
        o16 = n_ovr16;
        beat(5'd19, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send_frame(1);
        wait_result(15 * 1 + 4, "tie");
        check_result("tie", 4'd3, 32'd500, 4'd3, 32'd500);
        check("oor_no_overrun", 64'(n_ovr16 - o16), 64'd0);

        // Saturating product.
        for (int i = 0; i < NB; i++) fbins[i] = '0;
        fbins[4] = 32'hFFFF_FFFF; fbins[8] = 32'hFFFF_FFFF;
        send_frame(2);
        wait_result(7 * 2 + 4, "sat");
        check_result("sat", 4'd4, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFF);

        // Beats during the scan are dropped and flagged, and leave RAM and the result untouched.
        for (int i = 0; i < NB; i++) fbins[i] = '0;
        fbins[2] = 32'h1_0000; fbins[4] = 32'h1_0000; fbins[6] = 32'h1_0000;
        send_frame(3);
        o16 = n_ovr16;
        o0  = n_ovr0;
        beat(5'd2,  32'h0000_DEAD, 1'b0, 1'b0);
        beat(5'd20, 32'h0000_BEEF, 1'b0, 1'b0);
        beat(5'd4,  32'h0000_0005, 1'b1, 1'b0);
        wait_result(5 * 3 + 4, "ovr");
        check("ovr_count16", 64'(n_ovr16 - o16), 64'd3);
        check("ovr_count0",  64'(n_ovr0 - o0),   64'd3);
        check_result("ovr", 4'd2, 32'h1_0000, 4'd2, 32'hFFFF_FFFF);
        send_last_only(3);
        wait_result(5 * 3 + 4, "ovr_ram");
        check_result("ovr_ram", 4'd2, 32'h1_0000, 4'd2, 32'hFFFF_FFFF);

        // Harmonic count 7 clamps to 5 (K_END=3); count 0 acts as 1 on the persisted spectrum.
        for (int i = 0; i < NB; i++) fbins[i] = 32'h1_0000;
        fbins[0] = '0; fbins[3] = 32'h2_0000; fbins[15] = 32'h3_0000;
        send_frame(7);
        wait_result(3 * 5 + 4, "clamp");
        check_result("clamp", 4'd3, 32'h6_0000, 4'd1, 32'hFFFF_FFFF);
        send_last_only(0);
        wait_result(15 * 1 + 4, "h0");
        check_result("h0", 4'd15, 32'h3_0000, 4'd15, 32'h3_0000);

        // Reset in the middle of a scan aborts it without a result pulse.
        send_last_only(3);
        repeat (4) @(posedge clock);
        #1;
        check("pre_rst_busy", 64'(busy16), 64'd1);
        r0 = n_rep;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_busy16", 64'(busy16), 64'd0);
        check("midrst_busy0",  64'(busy0),  64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("midrst_no_pulse", 64'(n_rep - r0), 64'd0);
        check_result("midrst_clear", 4'd0, 32'd0, 4'd0, 32'd0);
        send_last_only(3);
        wait_result(5 * 3 + 4, "after_rst");
        check_result("after_rst", 4'd5, 32'h3_0000, 4'd1, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
